// File: rtl/apb_master_n.sv
// APB master with a command FIFO, built-in address decode for up to 16 slaves,
// error responses for unmapped addresses and a PREADY timeout.
module apb_master_n #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32,
  parameter logic [15:0] BASE_HI    = 16'h1000,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         transfer,
  input  logic                         write,
  input  logic [31:0]                  addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         req_ready,
  output logic                         ready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         err,
  output logic [31:0]                  PADDR,
  output logic                         PWRITE,
  output logic                         PENABLE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CMD_W = 1 + 32 + DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [3:0]          idx_q, idx_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                fifo_full, fifo_empty, push, pop, load, finish;
  logic [CMD_W-1:0]    head;
  logic                head_write, head_mapped;
  logic [31:0]         head_addr;
  logic [DATA_W-1:0]   head_wdata;
  logic                sel_pready, sel_pslverr;
  logic [DATA_W-1:0]   sel_prdata;

  assign fifo_full  = (count_q == OCC_W'(CMD_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = transfer && !fifo_full;
  assign req_ready  = !fifo_full;

  // The head entry is only looked at when the FIFO is non-empty.
  assign head        = fifo_mem[rd_ptr_q];
  assign head_write  = head[CMD_W-1];
  assign head_addr   = head[DATA_W +: 32];
  assign head_wdata  = head[DATA_W-1:0];
  assign head_mapped = (head_addr[31:16] == BASE_HI) &&
                       ({1'b0, head_addr[15:12]} < 5'(NUM_SLAVES));

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = (state_q == ACCESS);
  assign ready   = ready_q;
  assign err     = err_q;
  assign rdata   = rdata_q;

  // One select line per slave, active through SETUP and ACCESS.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
    assign PSEL[gi] = (state_q != IDLE) && (idx_q == 4'(gi));
  end

  // Command storage: plain array, no reset, so the pointers alone flush it.
  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {write, addr, wdata};
    end
  end

  // Pick ready/error/data of the currently addressed slave only.
  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_pready  = PREADY[i];
        sel_pslverr = PSLVERR[i];
        sel_prdata  = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, pop decision, timeout counting and response generation.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_mapped) begin
            load    = 1'b1;
            state_d = SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_pready) begin
          finish  = 1'b1;
          ready_d = 1'b1;
          err_d   = sel_pslverr;
          rdata_d = pwrite_q ? '0 : sel_prdata;
        end else if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // An unmapped head is left for IDLE so its error response stays in order.
        if (finish) begin
          if (!fifo_empty && head_mapped) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cnt_d = '0;
    end
  end

  // Pointer/occupancy updates and capture of the APB request fields.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
    paddr_d  = load ? head_addr        : paddr_q;
    pwrite_d = load ? head_write       : pwrite_q;
    pwdata_d = load ? head_wdata       : pwdata_q;
    idx_d    = load ? head_addr[15:12] : idx_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_n.sv
// Bench for apb_master_n: slave models with configurable wait/error/hang,
// a response scoreboard and one task per scenario.
module tb_apb_master_n;
  localparam int NS = 4;
  localparam int DW = 32;

  logic PCLK = 1'b0;
  logic PRESET = 1'b0;
  logic transfer, write;
  logic [31:0] addr;
  logic [DW-1:0] wdata;
  logic req_ready, ready, err, PWRITE, PENABLE;
  logic [DW-1:0] rdata, PWDATA;
  logic [31:0] PADDR;
  logic [NS-1:0] PSEL, PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  psel;
  } exp_t;

  exp_t sb[$];
  int   ready_times[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready_count = 0;
  logic [3:0] cur_psel;

  int   wait_cfg[NS];
  bit   hang[NS];
  bit   err_cfg[NS];
  bit   noise;
  logic [31:0] smem [NS][16];
  int   acc_cnt = 0;

  apb_master_n #(.NUM_SLAVES(NS), .DATA_W(DW), .BASE_HI(16'h1000),
                 .CMD_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .req_ready(req_ready), .ready(ready),
    .rdata(rdata), .err(err), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Wait-state counter shared by all slave models.
  always @(posedge PCLK) begin
    if (PENABLE && !(|(PSEL & PREADY))) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Slave memories, word-indexed by PADDR[5:2].
  always @(posedge PCLK) begin
    for (int i = 0; i < NS; i++) begin
      if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) smem[i][PADDR[5:2]] <= PWDATA;
    end
  end

  // Slave responses; with noise set, unselected slaves shout ready+error.
  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    PRDATA  = '0;
    for (int i = 0; i < NS; i++) begin
      PRDATA[i*DW +: DW] = smem[i][PADDR[5:2]];
      if (PSEL[i]) begin
        PREADY[i]  = PENABLE && !hang[i] && (acc_cnt >= wait_cfg[i]);
        PSLVERR[i] = err_cfg[i];
      end else if (noise) begin
        PREADY[i]  = 1'b1;
        PSLVERR[i] = 1'b1;
      end
    end
  end

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESET && ready) begin
        ready_count++;
        ready_times.push_back(cyc);
        $display("[TB] resp edge=%0d rdata=%h err=%b psel=%b", cyc, rdata, err, cur_psel);
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ready: got ready with rdata=%h err=%b, required no pending response", rdata, err);
        end else begin
          e = sb.pop_front();
          tests++;
          if (rdata !== e.rdata) begin
            fails++; $display("FAIL resp_rdata: got %h required %h", rdata, e.rdata);
          end
          tests++;
          if (err !== e.err) begin
            fails++; $display("FAIL resp_err: got %b required %b (rdata exp %h)", err, e.err, e.rdata);
          end
          tests++;
          if (cur_psel !== e.psel) begin
            fails++; $display("FAIL resp_psel: got %b required %b", cur_psel, e.psel);
          end
        end
        cur_psel = '0;
      end
      if (PRESET && PSEL != '0 && !PENABLE) cur_psel = PSEL;
    end
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee, input logic [3:0] ep,
                          output bit accepted, output int acc_cyc);
    exp_t e;
    transfer = 1'b1; write = w; addr = a; wdata = d;
    accepted = req_ready;
    @(posedge PCLK);
    if (accepted) begin
      e.rdata = er; e.err = ee; e.psel = ep;
      sb.push_back(e);
    end
    #1;
    acc_cyc = cyc;
    $display("[TB] req edge=%0d %s addr=%h wdata=%h accepted=%0d", acc_cyc, w ? "WR" : "RD", a, d, accepted);
    transfer = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge PCLK); #1; n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL %s_drain: %0d responses pending, required 0", tag, sb.size());
    end
  endtask

  task automatic check_lat(input string tag, input int got_idx, input int required);
    int got;
    got = (ready_times.size() > got_idx) ? ready_times[got_idx] : -1;
    tests++;
    if (got != required) begin
      fails++; $display("FAIL %s: ready at edge %0d, required %0d", tag, got, required);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b0;
    #12;
    tests++; if (PSEL !== '0)    begin fails++; $display("FAIL reset_psel: got %b required 0", PSEL); end
    tests++; if (PENABLE !== 1'b0) begin fails++; $display("FAIL reset_penable: got %b required 0", PENABLE); end
    tests++; if (PWRITE !== 1'b0) begin fails++; $display("FAIL reset_pwrite: got %b required 0", PWRITE); end
    tests++; if (PADDR !== '0)   begin fails++; $display("FAIL reset_paddr: got %h required 0", PADDR); end
    tests++; if (PWDATA !== '0)  begin fails++; $display("FAIL reset_pwdata: got %h required 0", PWDATA); end
    tests++; if ({ready, err} !== 2'b00) begin fails++; $display("FAIL reset_ready_err: got %b required 00", {ready, err}); end
    tests++; if (rdata !== '0)   begin fails++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_ram();
    bit acc; int t0;
    push_req(1, 32'h1000_0000, 1, 0, 0, 4'b0001, acc, t0);
    push_req(1, 32'h1000_0004, 2, 0, 0, 4'b0001, acc, t0);
    push_req(1, 32'h1000_0008, 3, 0, 0, 4'b0001, acc, t0);
    push_req(0, 32'h1000_0000, 0, 1, 0, 4'b0001, acc, t0);
    push_req(0, 32'h1000_0004, 0, 2, 0, 4'b0001, acc, t0);
    push_req(0, 32'h1000_0008, 0, 3, 0, 4'b0001, acc, t0);
    drain("ram");
    ready_times.delete();
    push_req(0, 32'h1000_0004, 0, 2, 0, 4'b0001, acc, t0);
    drain("ram_single");
    check_lat("ram_read_latency", 0, t0 + 3);
  endtask

  task automatic test_slave_select();
    bit acc; int t0;
    push_req(1, 32'h1000_1000, 11, 0, 0, 4'b0010, acc, t0);
    push_req(1, 32'h1000_2000, 12, 0, 0, 4'b0100, acc, t0);
    push_req(0, 32'h1000_1000, 0, 11, 0, 4'b0010, acc, t0);
    push_req(0, 32'h1000_2000, 0, 12, 0, 4'b0100, acc, t0);
    drain("slave_select");
  endtask

  task automatic test_back_to_back();
    bit acc; int t0, tn;
    bit accepted[6];
    bit exp_acc[6] = '{1, 1, 1, 1, 1, 0};
    // Four consecutive requests to rotating slaves: no IDLE gap between transfers.
    ready_times.delete();
    push_req(1, 32'h1000_0010, 32'hA0, 0, 0, 4'b0001, acc, t0);
    push_req(1, 32'h1000_1010, 32'hA1, 0, 0, 4'b0010, acc, tn);
    push_req(1, 32'h1000_2010, 32'hA2, 0, 0, 4'b0100, acc, tn);
    push_req(1, 32'h1000_3010, 32'hA3, 0, 0, 4'b1000, acc, tn);
    drain("b2b");
    for (int k = 0; k < 4; k++) check_lat("b2b_ready_slot", k, t0 + 3 + 2 * k);
    // First request occupies a slow slave, four more fill the FIFO, the last is dropped.
    wait_cfg[3] = 6;
    for (int k = 0; k < 5; k++)
      push_req(1, 32'h1000_3000 + 32'(4 * k), 32'hB0 + 32'(k), 0, 0, 4'b1000, accepted[k], tn);
    push_req(1, 32'h1000_3000, 32'hDEAD, 0, 0, 4'b1000, accepted[5], tn);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (accepted[k] != exp_acc[k]) begin
        fails++; $display("FAIL b2b_accept[%0d]: got req_ready=%0d required %0d", k, accepted[k], exp_acc[k]);
      end
    end
    drain("b2b_full");
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_req_ready_after: got %b required 1", req_ready); end
    wait_cfg[3] = 0;
    push_req(0, 32'h1000_3000, 0, 32'hB0, 0, 4'b1000, acc, tn);
    drain("b2b_dropped_readback");
  endtask

  task automatic test_unmapped();
    bit acc; int t0;
    ready_times.delete();
    push_req(0, 32'h2000_0000, 0, 0, 1, 4'b0000, acc, t0);
    drain("unmapped_base");
    check_lat("unmapped_base_latency", 0, t0 + 1);
    ready_times.delete();
    push_req(1, 32'h1000_F000, 32'h55, 0, 1, 4'b0000, acc, t0);
    drain("unmapped_index");
    check_lat("unmapped_index_latency", 0, t0 + 1);
  endtask

  task automatic test_timeout_err();
    bit acc; int t0;
    hang[0] = 1'b1; noise = 1'b1;
    ready_times.delete();
    push_req(0, 32'h1000_0000, 0, 0, 1, 4'b0001, acc, t0);
    drain("timeout");
    check_lat("timeout_latency", 0, t0 + 18);
    hang[0] = 1'b0; noise = 1'b0;
    err_cfg[1] = 1'b1; wait_cfg[1] = 2;
    ready_times.delete();
    push_req(1, 32'h1000_1008, 32'h77, 0, 1, 4'b0010, acc, t0);
    drain("slverr_write");
    check_lat("slverr_latency", 0, t0 + 5);
    push_req(0, 32'h1000_1000, 0, 11, 1, 4'b0010, acc, t0);
    drain("slverr_read");
    err_cfg[1] = 1'b0; wait_cfg[1] = 0;
  endtask

  task automatic test_reset_mid();
    bit acc; int t0, n, base;
    logic [3:0] psel_any;
    wait_cfg[0] = 10;
    push_req(0, 32'h1000_0000, 0, 1, 0, 4'b0001, acc, t0);
    push_req(0, 32'h1000_0004, 0, 2, 0, 4'b0001, acc, t0);
    push_req(0, 32'h1000_0008, 0, 3, 0, 4'b0001, acc, t0);
    n = 0;
    while (!PENABLE && n < 50) begin @(posedge PCLK); #1; n++; end
    tests++;
    if (PENABLE !== 1'b1) begin fails++; $display("FAIL rstmid_access: got PENABLE=%b required 1", PENABLE); end
    #2;
    PRESET = 1'b0;
    #1;
    tests++; if (PSEL !== '0) begin fails++; $display("FAIL rstmid_psel: got %b required 0", PSEL); end
    tests++; if (PENABLE !== 1'b0) begin fails++; $display("FAIL rstmid_penable: got %b required 0", PENABLE); end
    tests++; if (PADDR !== '0) begin fails++; $display("FAIL rstmid_paddr: got %h required 0", PADDR); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_req_ready: got %b required 1", req_ready); end
    sb.delete();
    cur_psel = '0;
    base = ready_count;
    @(negedge PCLK);
    PRESET = 1'b1;
    psel_any = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge PCLK); #1;
      psel_any = psel_any | PSEL;
    end
    tests++;
    if (ready_count != base) begin fails++; $display("FAIL rstmid_no_ready: got %0d pulses required 0", ready_count - base); end
    tests++;
    if (psel_any !== '0) begin fails++; $display("FAIL rstmid_no_psel: got %b required 0", psel_any); end
    wait_cfg[0] = 0;
    push_req(0, 32'h1000_1000, 0, 11, 0, 4'b0010, acc, t0);
    drain("after_reset");
  endtask

  initial begin
    transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    cur_psel = '0; noise = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; hang[i] = 1'b0; err_cfg[i] = 1'b0;
    end
    fork
      monitor();
      begin
        repeat (50000) @(posedge PCLK);
        $display("FAIL watchdog: run not finished, required completion within 50000 cycles");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_ram();
    test_slave_select();
    test_back_to_back();
    test_unmapped();
    test_timeout_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
